atm_controller: RTL and testbench
=================================

Name: atm_controller

Overview:
- Bank ATM session controller: one Moore FSM that sequences card insertion, card validation, language choice, PIN entry/verification, the operation menu (deposit, withdraw, balance, other services), the "another transaction?" prompt and card ejection.
- Sits between the ATM front-panel and sensor flags and the display/dispatch logic. It reports its current state as a 5-bit action code.
- All inputs are level flags, sampled on the rising clock edge.

Parameters:
- PASSWORD, 4'b1111, correct PIN compared against InPass.
- MAX_TRIES, 3, number of wrong PIN entries that retains the card.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ic  in  1  card inserted.
- cv  in  1  card valid (sampled in CHECK_CARD).
- cl  in  1  language chosen.
- ep  in  1  PIN entry complete.
- InPass  in  4  entered PIN.
- co  in  2  chosen operation: 00 deposit, 01 withdraw, 10 balance, 11 other services.
- mi  in  1  money inserted (deposit).
- mc  in  1  money counted/confirmed (deposit).
- ai  in  1  withdraw amount entered.
- vb  in  1  balance sufficient for the withdraw amount.
- Mm  in  1  customer wants another transaction.
- CNL  in  1  cancel request.
- action  out  5  current state code, registered, equal to the state number below.

Behaviour:
- Reset: rst_n=0 asynchronously forces state S0, action=5'd0 and the PIN try counter to 0.
- Output: action = state number (Sn -> n). It changes only on a clock edge, one cycle after the qualifying input.
- "Hold" means stay in the current state if no listed condition is true.
- Transitions, evaluated every rising edge:
  - S0 IDLE: ic=1 -> S1; else hold. Entering S0 clears the try counter.
  - S1 CHECK_CARD: cv=1 -> S2; cv=0 -> S15.
  - S2 LANGUAGE: cl=1 -> S3; else hold.
  - S3 PIN_ENTRY: ep=1 -> S4; else hold.
  - S4 VERIFY: InPass==PASSWORD -> S5 and the counter clears. Otherwise the counter increments: if the new count equals MAX_TRIES -> S16, else -> S3.
  - S5 MENU: co=00 -> S6, 01 -> S11, 10 -> S8, 11 -> S9.
  - S6 DEP_INSERT: mi=1 -> S7; else hold.
  - S7 DEP_COUNT: mc=1 -> S10; mc=0 -> S6 (re-insert).
  - S8 BALANCE: -> S14 unconditionally.
  - S9 OTHER_SERVICES: -> S14 unconditionally.
  - S10 DEPOSIT_DONE: -> S14.
  - S11 WD_AMOUNT: ai=1 -> S12; else hold.
  - S12 WD_CHECK: vb=1 -> S13; vb=0 -> S17.
  - S13 WITHDRAW_DONE (dispense): -> S14.
  - S14 ANOTHER: Mm=1 -> S5; Mm=0 -> S15.
  - S15 EJECT_CARD: -> S0.
  - S16 CARD_RETAINED: -> S0.
  - S17 INSUFFICIENT: -> S14.
- Cancel: CNL=1 in any of S1..S14 or S17 -> S15 next edge. CNL has the highest priority over every other input. CNL is ignored in S0, S15 and S16.
- Unused codes 18..31 -> S0 next edge (safe recovery).
- Try counter: 2 bits wide. It persists across S3/S4 loops within one session and saturates at MAX_TRIES.
- Inputs held constant for many cycles are legal. The FSM simply keeps advancing, e.g. Mm=1 held loops S14->S5->... back into the selected operation.
- Reset asserted mid-session aborts immediately to S0. There is no eject state on reset.

Test Plan:
- Deposit: reset, then ic=cv=cl=ep=1, InPass=1111, co=00, mi=mc=1, Mm=1, CNL=0 -> action 0,1,2,3,4,5,6,7,10,14,5 on successive edges.
- Withdraw: same setup with co=01, ai=vb=1 -> 5,11,12,13,14. Repeat with vb=0 -> 12,17,14. With Mm=0 -> 15 then 0.
- Balance/other: co=10 -> 5,8,14. co=11 -> 5,9,14.
- Wrong PIN: InPass=1100, ep=1 held -> 3,4,3,4,3,4,16,0. Check the counter reaches 3 only once per session; a correct PIN after 2 failures reaches S5.
- Cancel/invalid card: cv=0 in S1 -> 15,0. CNL=1 asserted in S6 or S11 -> 15 next edge, then 0.
- Async reset: drop rst_n between clock edges while in S12 -> action=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/atm_controller.sv
// ATM session controller: Moore FSM covering card, language, PIN, the operation menu and eject.
// The action output is the state register itself, so it only changes on a clock edge.
module atm_controller #(
  parameter logic [3:0] PASSWORD  = 4'b1111,
  parameter int         MAX_TRIES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ic,
  input  logic       cv,
  input  logic       cl,
  input  logic       ep,
  input  logic [3:0] InPass,
  input  logic [1:0] co,
  input  logic       mi,
  input  logic       mc,
  input  logic       ai,
  input  logic       vb,
  input  logic       Mm,
  input  logic       CNL,
  output logic [4:0] action
);

  // state            | meaning
  // S_IDLE        0  | waiting for a card, try counter cleared
  // S_CHECK_CARD  1  | validating the card
  // S_LANGUAGE    2  | waiting for language choice
  // S_PIN_ENTRY   3  | waiting for PIN entry
  // S_VERIFY      4  | comparing PIN, counting failures
  // S_MENU        5  | operation selection
  // S_DEP_INSERT  6  | waiting for money
  // S_DEP_COUNT   7  | counting inserted money
  // S_BALANCE     8  | balance display
  // S_OTHER       9  | other services
  // S_DEP_DONE   10  | deposit complete
  // S_WD_AMOUNT  11  | waiting for withdraw amount
  // S_WD_CHECK   12  | checking balance against amount
  // S_WD_DONE    13  | dispensing cash
  // S_ANOTHER    14  | another transaction prompt
  // S_EJECT      15  | ejecting card
  // S_RETAINED   16  | card retained after too many wrong PINs
  // S_INSUFF     17  | insufficient balance notice
  typedef enum logic [4:0] {
    S_IDLE       = 5'd0,
    S_CHECK_CARD = 5'd1,
    S_LANGUAGE   = 5'd2,
    S_PIN_ENTRY  = 5'd3,
    S_VERIFY     = 5'd4,
    S_MENU       = 5'd5,
    S_DEP_INSERT = 5'd6,
    S_DEP_COUNT  = 5'd7,
    S_BALANCE    = 5'd8,
    S_OTHER      = 5'd9,
    S_DEP_DONE   = 5'd10,
    S_WD_AMOUNT  = 5'd11,
    S_WD_CHECK   = 5'd12,
    S_WD_DONE    = 5'd13,
    S_ANOTHER    = 5'd14,
    S_EJECT      = 5'd15,
    S_RETAINED   = 5'd16,
    S_INSUFF     = 5'd17
  } state_t;

  localparam logic [2:0] MAX_TRIES_C = 3'(MAX_TRIES);

  state_t     state, state_next;
  logic [1:0] tries, tries_next;
  logic [2:0] tries_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tries <= 2'd0;
    end else begin
      state <= state_next;
      tries <= tries_next;
    end
  end

  assign tries_inc = {1'b0, tries} + 3'd1;

  always_comb begin
    state_next = state;
    tries_next = tries;
    case (state)
      S_IDLE:       if (ic) state_next = S_CHECK_CARD;
      S_CHECK_CARD: state_next = cv ? S_LANGUAGE : S_EJECT;
      S_LANGUAGE:   if (cl) state_next = S_PIN_ENTRY;
      S_PIN_ENTRY:  if (ep) state_next = S_VERIFY;
      S_VERIFY: begin
        if (InPass == PASSWORD) begin
          state_next = S_MENU;
          tries_next = 2'd0;
        end else if (tries_inc >= MAX_TRIES_C) begin
          state_next = S_RETAINED;
          tries_next = MAX_TRIES_C[1:0];
        end else begin
          state_next = S_PIN_ENTRY;
          tries_next = tries_inc[1:0];
        end
      end
      S_MENU: begin
        case (co)
          2'b00:   state_next = S_DEP_INSERT;
          2'b01:   state_next = S_WD_AMOUNT;
          2'b10:   state_next = S_BALANCE;
          default: state_next = S_OTHER;
        endcase
      end
      S_DEP_INSERT: if (mi) state_next = S_DEP_COUNT;
      S_DEP_COUNT:  state_next = mc ? S_DEP_DONE : S_DEP_INSERT;
      S_BALANCE,
      S_OTHER,
      S_DEP_DONE,
      S_WD_DONE,
      S_INSUFF:     state_next = S_ANOTHER;
      S_WD_AMOUNT:  if (ai) state_next = S_WD_CHECK;
      S_WD_CHECK:   state_next = vb ? S_WD_DONE : S_INSUFF;
      S_ANOTHER:    state_next = Mm ? S_MENU : S_EJECT;
      S_EJECT,
      S_RETAINED:   state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase

    // Cancel overrides everything inside an active session; the counter is
    // left alone because the session is about to end anyway.
    if (CNL && state != S_IDLE && state != S_EJECT && state != S_RETAINED
        && state <= S_INSUFF) begin
      state_next = S_EJECT;
      tries_next = tries;
    end

    if (state_next == S_IDLE) tries_next = 2'd0;
  end

  assign action = state;

endmodule

// File: tb/tb_atm_controller.sv
// Scoreboard bench for atm_controller: stimulus queues expected action codes,
// a monitor pops and compares them on each falling edge.
module tb_atm_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ic = 0, cv = 0, cl = 0, ep = 0;
  logic [3:0] InPass = 4'd0;
  logic [1:0] co = 2'd0;
  logic       mi = 0, mc = 0, ai = 0, vb = 0, Mm = 0, CNL = 0;
  logic [4:0] action;

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];
  bit done = 0;

  atm_controller dut (
    .clk(clk), .rst_n(rst_n), .ic(ic), .cv(cv), .cl(cl), .ep(ep),
    .InPass(InPass), .co(co), .mi(mi), .mc(mc), .ai(ai), .vb(vb),
    .Mm(Mm), .CNL(CNL), .action(action)
  );

  always #5 clk = ~clk;

  // One rising edge, then queue the code expected after it.
  task automatic tick(input logic [4:0] e);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic ticks(input logic [4:0] seq[]);
    foreach (seq[i]) tick(seq[i]);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      e = exp_q.pop_front();
      checks++;
      if (action !== e) begin
        errors++;
        $display("FAIL action_seq t=%0t: got %0d expected %0d", $time, action, e);
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    tick(5'd0);
    tick(5'd0);
    rst_n = 1'b1;

    // deposit path with Mm held
    ic = 1; cv = 1; cl = 1; ep = 1; InPass = 4'b1111; co = 2'b00;
    mi = 1; mc = 1; Mm = 1; CNL = 0;
    ticks('{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd10, 5'd14, 5'd5});
    // recount: mc=0 goes back to insert
    mc = 0;
    ticks('{5'd6, 5'd7, 5'd6, 5'd7});
    mc = 1;
    ticks('{5'd10, 5'd14, 5'd5});

    // withdraw sufficient, then insufficient, then leave
    co = 2'b01; ai = 1; vb = 1;
    ticks('{5'd11, 5'd12, 5'd13, 5'd14, 5'd5});
    vb = 0;
    ticks('{5'd11, 5'd12, 5'd17, 5'd14, 5'd5});
    Mm = 0;
    ticks('{5'd11, 5'd12, 5'd17, 5'd14, 5'd15, 5'd0});

    // balance and other services
    Mm = 1; co = 2'b10;
    ticks('{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd14, 5'd5});
    co = 2'b11;
    ticks('{5'd9, 5'd14, 5'd5});

    // cancel in deposit insert, CNL ignored in S15
    co = 2'b00; mi = 0;
    ticks('{5'd6, 5'd6});
    CNL = 1;
    ticks('{5'd15, 5'd0});
    CNL = 0;

    // cancel while waiting for withdraw amount
    co = 2'b01; ai = 0;
    ticks('{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd11, 5'd11});
    CNL = 1;
    tick(5'd15);
    CNL = 0;
    tick(5'd0);

    // invalid card
    cv = 0;
    ticks('{5'd1, 5'd15, 5'd0});
    cv = 1;

    // wrong PIN three times, twice in two sessions
    InPass = 4'b1100;
    ticks('{5'd1, 5'd2, 5'd3, 5'd4, 5'd3, 5'd4, 5'd3, 5'd4, 5'd16, 5'd0});
    ticks('{5'd1, 5'd2, 5'd3, 5'd4, 5'd3, 5'd4, 5'd3, 5'd4, 5'd16, 5'd0});

    // correct PIN after two failures
    ticks('{5'd1, 5'd2, 5'd3, 5'd4, 5'd3, 5'd4, 5'd3});
    InPass = 4'b1111;
    ticks('{5'd4, 5'd5});

    // async reset while in WD_CHECK
    co = 2'b01; ai = 1; vb = 1;
    tick(5'd11);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.push_back(5'd0);
    tick(5'd0);
    ic = 0;
    rst_n = 1'b1;
    tick(5'd0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: got no finish expected finish before 100000");
      $fatal(1, "timeout");
    end
  end

endmodule
